uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one Uart8 transmitter among NUM_REQ byte requesters.
- Accepts byte requests, latches the granted byte and drives the Uart8 tx interface (txEn, txStart, in).
- Tracks txBusy/txDone, reports per-requester completion and enforces a programmable inter-byte idle gap.
- Sits between client logic (command/response engines) and the Uart8 tx port; Uart8's rx side is untouched.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and Uart8-tx bundle shared by the arbiter and its environment.
// slave: arbiter view. master: client/transmitter view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] reqByte;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   done;
  logic [IW-1:0]        grantId;
  logic                 uartTxEn;
  logic                 uartTxStart;
  logic [7:0]           uartIn;
  logic                 uartTxBusy;
  logic                 uartTxDone;

  modport slave (
    input  req, reqByte, uartTxBusy, uartTxDone,
    output ack, done, grantId, uartTxEn, uartTxStart, uartIn
  );

  modport master (
    output req, reqByte, uartTxBusy, uartTxDone,
    input  ack, done, grantId, uartTxEn, uartTxStart, uartIn
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one Uart8 transmitter among NUM_REQ byte requesters.
// Latency: req in IDLE -> ack + txStart next edge; GAP_CYCLES forced idle after each byte.
// Backpressure: requesters hold req until ack; START/WAIT stall on txBusy/txDone (watchdog via UART_TX_ARB_TIMEOUT_EN).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             en,
  uart_tx_arbiter_if.slave bus,
  output logic             busy,
  output logic             timeoutErr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Gap counter only needs to hold 0..GAP_CYCLES-1.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    req_bytes [NUM_REQ];
  logic          sel_vld;
  logic [IW-1:0] sel_id;
  logic [IW-1:0] cand;
  logic          tmo_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = bus.reqByte[8*i +: 8];
  end

  // Pick the first set req at or after ptr; scanning from the far end lets the nearest one win.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k >= NUM_REQ) ? IW'(int'(ptr) + k - NUM_REQ) : IW'(int'(ptr) + k);
      if (bus.req[cand]) begin
        sel_vld = 1'b1;
        sel_id  = cand;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo_hit = ((state == START) || (state == WAIT)) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit    = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  // Sequencer: arbitrate in IDLE, hand the byte to Uart8, wait for completion, then hold the gap.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state           <= IDLE;
      ptr             <= '0;
      gap_cnt         <= '0;
      busy            <= 1'b0;
      bus.ack         <= '0;
      bus.done        <= '0;
      bus.grantId     <= '0;
      bus.uartTxEn    <= 1'b0;
      bus.uartTxStart <= 1'b0;
      bus.uartIn      <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_cnt         <= '0;
      timeoutErr      <= 1'b0;
`endif
    end else begin
      bus.ack  <= '0;
      bus.done <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      // Free-running; cleared whenever START or WAIT is entered.
      tmo_cnt  <= tmo_cnt + 1'b1;
`endif
      if ((state != IDLE) && (!en || tmo_hit)) begin
        // Abort: the byte in flight is dropped, pointer keeps its advanced value.
        state           <= IDLE;
        busy            <= 1'b0;
        bus.uartTxEn    <= 1'b0;
        bus.uartTxStart <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (tmo_hit) timeoutErr <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (en && sel_vld) begin
              state           <= START;
              busy            <= 1'b1;
              bus.uartTxEn    <= 1'b1;
              bus.uartTxStart <= 1'b1;
              bus.uartIn      <= req_bytes[sel_id];
              bus.grantId     <= sel_id;
              bus.ack[sel_id] <= 1'b1;
              ptr             <= (sel_id == IW'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
              tmo_cnt         <= '0;
`endif
            end
          end
          START: begin
            if (bus.uartTxBusy) begin
              state           <= WAIT;
              bus.uartTxStart <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
              tmo_cnt         <= '0;
`endif
            end
          end
          WAIT: begin
            if (bus.uartTxDone && !bus.uartTxBusy) begin
              bus.done[bus.grantId] <= 1'b1;
              if (GAP_CYCLES == 0) begin
                state        <= IDLE;
                busy         <= 1'b0;
                bus.uartTxEn <= 1'b0;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state        <= IDLE;
              busy         <= 1'b0;
              bus.uartTxEn <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural Uart8 tx model and a done-side scoreboard.
// Expected grants are queued when requests are driven and checked on each done pulse.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int GAP     = 16;
  localparam int TMO     = 64;
  localparam int TX_CYC  = 20;

  typedef struct {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  logic clk;
  logic rstN;
  logic en;
  logic busy;
  logic timeout_err;
  logic stub;
  logic [7:0] tx_byte;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  bit have_done = 0;
  logic prev_start = 1'b0;
  int scnt = 0;
  int mcnt = 0;
  exp_t exp_q[$];
  exp_t e;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NREQ),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .en(en),
    .bus(bus),
    .busy(busy),
    .timeoutErr(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
    exp_t t;
    t.id  = id;
    t.dat = d;
    exp_q.push_back(t);
  endtask

  task automatic wait_ack(input int id, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < 200);
    check("ack_seen", 32'(n < 200), 32'd1);
    check("ack_id", 32'(bus.ack), 32'(1 << id));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(n < 400), 32'd1);
  endtask

  task automatic wait_txbusy();
    int n = 0;
    while (!bus.uartTxBusy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("txbusy_seen", 32'(n < 100), 32'd1);
  endtask

  // Uart8 tx model: txBusy two cycles after txStart, busy for TX_CYC cycles, then a txDone pulse.
  always @(negedge clk) begin
    if (!rstN || !bus.uartTxEn || stub) begin
      bus.uartTxBusy = 1'b0;
      bus.uartTxDone = 1'b0;
      scnt = 0;
      mcnt = 0;
    end else begin
      bus.uartTxDone = 1'b0;
      if (bus.uartTxBusy) begin
        mcnt++;
        if (mcnt == TX_CYC) begin
          bus.uartTxBusy = 1'b0;
          bus.uartTxDone = 1'b1;
        end
      end else if (bus.uartTxStart) begin
        scnt++;
        if (scnt == 2) begin
          bus.uartTxBusy = 1'b1;
          mcnt = 0;
          scnt = 0;
          tx_byte = bus.uartIn;
        end
      end
    end
  end

  // Scoreboard: each done pulse must match the oldest queued grant; also checks the post-done gap.
  always @(negedge clk) begin
    if (rstN && bus.done != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_vec", 32'(bus.done), 32'(1 << e.id));
        check("done_gid", 32'(bus.grantId), 32'(e.id));
        check("tx_byte", 32'(tx_byte), 32'(e.dat));
      end
      last_done = cyc;
      have_done = 1'b1;
    end
    if (bus.uartTxStart && !prev_start && have_done) begin
      check("gap_spacing", 32'((cyc - last_done) >= GAP), 32'd1);
      have_done = 1'b0;
    end
    prev_start = bus.uartTxStart;
  end

  initial begin
    int n;
    rstN        = 1'b0;
    en          = 1'b0;
    stub        = 1'b0;
    bus.req     = '0;
    bus.reqByte = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txen", 32'(bus.uartTxEn), 32'd0);
    check("rst_start", 32'(bus.uartTxStart), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_gid", 32'(bus.grantId), 32'd0);
    check("rst_uartin", 32'(bus.uartIn), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    rstN = 1'b1;
    en   = 1'b1;
    @(negedge clk);

    // Single request on line 1
    bus.reqByte[15:8] = 8'h8A;
    bus.req = 4'b0010;
    push_exp(2'd1, 8'h8A);
    wait_ack(1, n);
    check("t1_ack_lat", 32'(n), 32'd1);
    check("t1_uartin", 32'(bus.uartIn), 32'h8A);
    check("t1_start", 32'(bus.uartTxStart), 32'd1);
    check("t1_txen", 32'(bus.uartTxEn), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_gid", 32'(bus.grantId), 32'd1);
    bus.req = '0;
    bus.reqByte[15:8] = 8'hFF;
    wait_txbusy();
    @(negedge clk);
    check("t1_start_drop", 32'(bus.uartTxStart), 32'd0);
    wait_idle();
    check("t1_txen_idle", 32'(bus.uartTxEn), 32'd0);

    // Contention after reset: all four lines, order 0,1,2,3
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    bus.reqByte = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req = 4'b1111;
    push_exp(2'd0, 8'h11);
    push_exp(2'd1, 8'h22);
    push_exp(2'd2, 8'h33);
    push_exp(2'd3, 8'h44);
    for (int i = 0; i < NREQ; i++) begin
      wait_ack(i, n);
      bus.req[i] = 1'b0;
    end
    wait_idle();

    // Fairness: lines 0 and 2 kept requesting, grants alternate 0,2,0,2
    bus.reqByte = {8'h00, 8'hC2, 8'h00, 8'hA0};
    bus.req = 4'b0101;
    push_exp(2'd0, 8'hA0);
    push_exp(2'd2, 8'hC2);
    push_exp(2'd0, 8'hA0);
    push_exp(2'd2, 8'hC2);
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (k % 2 == 0) ? 0 : 2;
      wait_ack(id, n);
      bus.req[id] = 1'b0;
      @(negedge clk);
      if (k < 2) bus.req[id] = 1'b1;
    end
    wait_idle();

    // Abort: en dropped mid-byte on line 3
    bus.reqByte[31:24] = 8'h7A;
    bus.req = 4'b1000;
    wait_ack(3, n);
    bus.req = '0;
    wait_txbusy();
    repeat (8) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("ab_txen", 32'(bus.uartTxEn), 32'd0);
    check("ab_start", 32'(bus.uartTxStart), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_gid", 32'(bus.grantId), 32'd3);
    repeat (40) @(negedge clk);
    check("ab_no_done_pending", 32'(exp_q.size()), 32'd0);
    bus.req = 4'b1000;
    push_exp(2'd3, 8'h7A);
    en = 1'b1;
    wait_ack(3, n);
    check("ab_reserve_lat", 32'(n), 32'd1);
    bus.req = '0;
    wait_idle();

    // Async reset mid-WAIT, then next grant goes to line 0
    bus.reqByte[15:8] = 8'h5B;
    bus.req = 4'b0010;
    wait_ack(1, n);
    bus.req = '0;
    wait_txbusy();
    repeat (3) @(negedge clk);
    check("ar_busy_before", 32'(busy), 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("ar_txen", 32'(bus.uartTxEn), 32'd0);
    check("ar_start", 32'(bus.uartTxStart), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_ack", 32'(bus.ack), 32'd0);
    check("ar_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    bus.reqByte = {8'h00, 8'hD2, 8'hD1, 8'hD0};
    bus.req = 4'b0111;
    push_exp(2'd0, 8'hD0);
    push_exp(2'd1, 8'hD1);
    push_exp(2'd2, 8'hD2);
    for (int i = 0; i < 3; i++) begin
      wait_ack(i, n);
      bus.req[i] = 1'b0;
    end
    wait_idle();

    // Transmitter never reports busy
    stub = 1'b1;
    bus.reqByte[7:0] = 8'hE1;
    bus.req = 4'b0001;
    wait_ack(0, n);
    bus.req = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    n = 0;
    while (bus.uartTxEn && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 32'(n), 32'(TMO));
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    rstN = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 32'(timeout_err), 32'd0);
    rstN = 1'b1;
`else
    repeat (200) @(negedge clk);
    check("st_start", 32'(bus.uartTxStart), 32'd1);
    check("st_busy", 32'(busy), 32'd1);
    check("st_txen", 32'(bus.uartTxEn), 32'd1);
    check("st_tmo", 32'(timeout_err), 32'd0);
`endif
    stub = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
